// File: rtl/hex_word_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hex_word_tx: streams a binary word as fixed-width ASCII hex (+ CR LF).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hex_word_tx #(
  parameter int NUM_BITS  = 32,
  parameter bit LOWERCASE = 1'b0,
  parameter bit SEND_CRLF = 1'b1
) (
  input  logic                clk_48mhz,
  input  logic                reset_n,
  input  logic [NUM_BITS-1:0] word_in,
  input  logic                word_valid,
  output logic                word_ready,
  output logic [7:0]          uart_in_data,
  output logic                uart_in_valid,
  input  logic                uart_in_ready,
  output logic                busy
);

  localparam int c_NDIG = (NUM_BITS + 3) / 4;
  localparam int c_W    = 4 * c_NDIG;
  localparam int c_DW   = $clog2(c_NDIG + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIGIT = 2'd1,
    S_CR    = 2'd2,
    S_LF    = 2'd3
  } state_t;

  state_t           r_state;
  logic [c_W-1:0]   r_shift;
  logic [c_DW-1:0]  r_d;
  logic [c_W-1:0]   w_ext;
  logic             w_accept;
  logic             w_xfer;

  generate
    if (c_W > NUM_BITS) begin : g_pad
      assign w_ext = {{(c_W - NUM_BITS){1'b0}}, word_in};
    end else begin : g_nopad
      assign w_ext = word_in;
    end
  endgenerate

  assign w_accept = word_valid & word_ready;
  assign w_xfer   = uart_in_valid & uart_in_ready;

  function automatic logic [7:0] to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    return (LOWERCASE ? 8'h57 : 8'h37) + {4'h0, nib};
  endfunction

  // r_shift holds the digits still to be sent, top nibble next.
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_shift       <= '0;
      r_d           <= '0;
      uart_in_data  <= 8'h00;
      uart_in_valid <= 1'b0;
      word_ready    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shift       <= w_ext << 4;
            r_d           <= c_DW'(c_NDIG - 1);
            uart_in_data  <= to_ascii(w_ext[c_W-1 -: 4]);
            uart_in_valid <= 1'b1;
            word_ready    <= 1'b0;
            busy          <= 1'b1;
            r_state       <= S_DIGIT;
          end else begin
            word_ready <= 1'b1;
          end
        end
        S_DIGIT: begin
          if (w_xfer) begin
            if (r_d != '0) begin
              uart_in_data <= to_ascii(r_shift[c_W-1 -: 4]);
              r_shift      <= r_shift << 4;
              r_d          <= r_d - c_DW'(1);
            end else if (SEND_CRLF) begin
              uart_in_data <= 8'h0D;
              r_state      <= S_CR;
            end else begin
              uart_in_valid <= 1'b0;
              busy          <= 1'b0;
              word_ready    <= 1'b1;
              r_state       <= S_IDLE;
            end
          end
        end
        S_CR: begin
          if (w_xfer) begin
            uart_in_data <= 8'h0A;
            r_state      <= S_LF;
          end
        end
        S_LF: begin
          if (w_xfer) begin
            uart_in_valid <= 1'b0;
            busy          <= 1'b0;
            word_ready    <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
